// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, read-back and memory-port signals around the shared memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_done;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  sel;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_done, d_done, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory, as seen from outside the arbiter
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_done, d_done, rdata, sel, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer giving instruction fetch and data access turns on one memory port.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]            state;
    logic                  sel_q;
    logic                  last_grant;   // 0 = I, 1 = D
    logic                  i_done_q;
    logic                  d_done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic                  i_elig;
    logic                  d_elig;
    logic                  grant_d;
    logic                  mem_req_c;

    // A requester whose done pulse is high this cycle is not eligible again yet
    assign i_elig  = bus.i_req & ~i_done_q;
    assign d_elig  = bus.d_req & ~d_done_q;
    assign grant_d = d_elig & (~i_elig | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= 1'b0;
            last_grant <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_elig | d_elig) begin
                        sel_q <= grant_d;
                        state <= grant_d ? BUSY_D : BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ready) begin
                        rdata_q    <= bus.mem_rdata;
                        i_done_q   <= 1'b1;
                        last_grant <= 1'b0;
                        state      <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ready) begin
                        rdata_q    <= bus.mem_rdata;
                        d_done_q   <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_c = (state != IDLE);
        addr_mux  = sel_q ? bus.d_addr : bus.i_addr;
    end

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_req_c & sel_q & bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.sel       = sel_q;
    assign bus.rdata     = rdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the RISC-V core. The instruction-fetch side (I) and the data load/store side (D) each issue requests. The block grants one of them, holds the address/data mux select stable for the whole memory transaction, waits for the memory handshake, and returns a registered read word with a one-cycle done pulse. Ties are broken round-robin, so neither side can starve the other.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port
- DATA_WIDTH, 32, data width of read and write words

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction-fetch request (read only)
- i_addr  in  ADDR_WIDTH  fetch address
- i_done  out  1  one-cycle pulse: fetch complete, rdata valid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_done  out  1  one-cycle pulse: data access complete
- rdata  out  DATA_WIDTH  registered read word, shared by both requesters
- sel  out  1  current owner / mux select: 0 = I, 1 = D
- mem_req  out  1  memory request, high for the whole transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Eligibility: I is eligible when i_req=1 and i_done=0. D is eligible when d_req=1 and d_done=0. This means a requester's req is ignored in the cycle its done pulse is high.
- IDLE, one side eligible: go to that side's BUSY state. sel <= owner.
- IDLE, both sides eligible: grant the side that did not win the last grant. The last_grant register resets to I, so D wins the first tie after reset.
- IDLE, none eligible: stay in IDLE. sel holds its value.
- BUSY_x: mem_req=1. On mem_ready=1, capture mem_rdata into rdata, pulse x_done for the next cycle, update last_grant, and go to IDLE.
- Mux (combinational from registered sel):
  - mem_addr = sel ? d_addr : i_addr
  - mem_wdata = d_wdata
  - mem_we = mem_req & sel & d_we
- On a D store, rdata is still loaded with mem_rdata. Its value is don't-care for the requester.
- Requesters must hold req, addr, we and wdata stable from request until done.
- If a requester drops req while its state is BUSY, the transaction still completes and its done still pulses. A memory access is never aborted.
- mem_ready in IDLE is ignored.

## Timing
- Reset values: state=IDLE, sel=0, last_grant=I, mem_req=0, mem_we=0, i_done=0, d_done=0, rdata=0. mem_addr therefore equals i_addr.
- Reset asserted mid-transaction: the next cycle is IDLE with mem_req=0 and no done pulse. A mem_ready arriving in the same cycle as rst is discarded.
- Latency:
  - request seen in IDLE at edge 0 → BUSY with mem_req=1 and sel valid from cycle 1
  - mem_ready high in cycle k (k≥1) → done=1 and rdata valid in cycle k+1, with state IDLE
- Minimum turnaround: 3 cycles per access (request, 1-cycle memory, done/IDLE).
- Earliest next grant decision is in the done cycle, for the other requester only. The same requester can be re-granted one cycle later.
- sel changes only on the IDLE→BUSY edge and is stable throughout BUSY.
- Done pulses are exactly one cycle wide. i_done and d_done are never high together.

## Test plan
- Single fetch: rst released, i_req=1, i_addr=32'h00000010, mem_ready at cycle 1, mem_rdata=32'h12345678 → mem_req=1, sel=0, mem_addr=32'h10 in cycle 1; i_done=1 and rdata=32'h12345678 in cycle 2; d_done stays 0.
- Store with wait states: d_req=1, d_we=1, d_addr=32'h100, d_wdata=32'h87654321, mem_ready held low 3 cycles → mem_req, mem_we and sel=1 stay stable for 4 cycles; d_done pulses once the cycle after mem_ready.
- Contention: i_req and d_req held high for 4 transactions, 1-cycle memory → grants go D, I, D, I. Done pulses alternate, each one cycle wide.
- Load data path: d_req=1, d_we=0, mem_rdata=32'h11112222 → mem_we=0 throughout; d_done with rdata=32'h11112222; i_done stays 0.
- Reset mid-transaction: rst=1 while BUSY_D and before mem_ready → next cycle is IDLE with mem_req=0, no d_done, sel=0. With both requests pending after reset release, D is granted first.
- Request withdrawn: i_req dropped one cycle into BUSY_I → transaction still completes and i_done pulses once. With i_req low, no re-grant follows.
